// File: rtl/udm_seq_mult_ctrl.sv
// udm_seq_mult_ctrl
//   Builds one WIDTH x WIDTH unsigned product from four passes through a shared
//   combinational SUB x SUB multiplier tile. The tile is driven with one pair of
//   operand halves per cycle, and the partial products are shift-accumulated.
//   The result is then offered on a valid/ready handshake.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake; in_a, in_b unsigned operands
//   mul_a/mul_b          operand halves to the tile (0 when not multiplying)
//   mul_z                tile result, combinational from mul_a/mul_b
//   out_valid/out_ready  product handshake; product = accumulator
//   busy                 high while an operation is in flight (MUL or DONE)
//   op_count             completed handoffs, wraps modulo 2^CNT_W
module udm_seq_mult_ctrl #(
    parameter int WIDTH = 8,
    parameter int SUB   = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [SUB-1:0]     mul_a,
    output logic [SUB-1:0]     mul_b,
    input  logic [2*SUB-1:0]   mul_z,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         step_q, step_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [SUB-1:0]     mul_a_q, mul_a_d;
    logic [SUB-1:0]     mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] pp_sh;

    always_comb begin
        // Zero-extend the tile result to accumulator width.
        pp = {{(2*WIDTH-2*SUB){1'b0}}, mul_z};
        // step[0] selects the A half and step[1] selects the B half, so the
        // weight is SUB per high half that is used.
        case (step_q)
            2'd0:    pp_sh = pp;
            2'd1,
            2'd2:    pp_sh = pp << SUB;
            default: pp_sh = pp << (2*SUB);
        endcase
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_a_d  = in_a;
                    op_b_d  = in_b;
                    acc_d   = '0;
                    step_d  = 2'd0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d  = acc_q + pp_sh;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3)
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The outputs are registered, so they are decoded from the next state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        if (state_d == MUL) begin
            mul_a_d = step_d[0] ? op_a_d[WIDTH-1:SUB] : op_a_d[SUB-1:0];
            mul_b_d = step_d[1] ? op_b_d[WIDTH-1:SUB] : op_b_d[SUB-1:0];
        end else begin
            mul_a_d = '0;
            mul_b_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= 2'd0;
            acc_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign product   = acc_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_udm_seq_mult_ctrl.sv
// Directed bench for udm_seq_mult_ctrl using an exact tile model.
// The counter is built 4 bits wide so that the wrap from all-ones to zero
// is reached in a few dozen operations.
module tb_udm_seq_mult_ctrl;

    localparam int WIDTH = 8;
    localparam int SUB   = 4;
    localparam int CNT_W = 4;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [SUB-1:0]     mul_a;
    logic [SUB-1:0]     mul_b;
    logic [2*SUB-1:0]   mul_z;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;
    logic [CNT_W-1:0]   op_count;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    udm_seq_mult_ctrl #(.WIDTH(WIDTH), .SUB(SUB), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
        .out_valid(out_valid), .out_ready(out_ready), .product(product),
        .busy(busy), .op_count(op_count)
    );

    // Exact tile
    assign mul_z = {4'b0, mul_a} * {4'b0, mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One operation with a single-cycle in_valid. The product is held for a
    // couple of cycles before it is handed off.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input string tag);
        int n;
        logic [15:0] exp;
        exp = {8'h00, a} * {8'h00, b};
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd4);
        check({tag, " product"}, 32'(product), 32'(exp));
        tick();
        check({tag, " held"}, 32'(product), 32'(exp));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " idle"}, 32'(in_ready), 32'd1);
    endtask

    logic [7:0]  bb_a [3] = '{8'h00, 8'h80, 8'h0F};
    logic [7:0]  bb_b [3] = '{8'hFF, 8'h02, 8'hF0};
    logic [15:0] bb_p [3] = '{16'h0000, 16'h0100, 16'h0E10};
    logic [3:0]  exp_a [4] = '{4'hC, 4'h3, 4'hC, 4'h3};
    logic [3:0]  exp_b [4] = '{4'h5, 4'h5, 4'hA, 4'hA};

    initial begin
        int j, k, last, n;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

        // Reset, held for 3 cycles
        repeat (3) tick();
        rst = 1'b0;
        check("rst in_ready",  32'(in_ready),  32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy",      32'(busy),      32'd0);
        check("rst product",   32'(product),   32'd0);
        check("rst mul_a",     32'(mul_a),     32'd0);
        check("rst mul_b",     32'(mul_b),     32'd0);
        check("rst op_count",  32'(op_count),  32'd0);

        // Reset pulsed during step 2 discards the operation
        in_a = 8'h12; in_b = 8'h34; in_valid = 1'b1;
        tick();                      // accepted; now in step 0
        in_valid = 1'b0;
        check("abort busy", 32'(busy), 32'd1);
        tick(); tick();              // step 2
        check("abort step2 mul_a", 32'(mul_a), 32'h2);
        check("abort step2 mul_b", 32'(mul_b), 32'h3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort idle",     32'(in_ready), 32'd1);
        check("abort busy0",    32'(busy),     32'd0);
        check("abort product",  32'(product),  32'd0);
        check("abort mul_a",    32'(mul_a),    32'd0);
        check("abort op_count", 32'(op_count), 32'd0);
        n = 0;
        repeat (8) begin
            if (out_valid) n++;
            tick();
        end
        check("abort no out_valid", 32'(n), 32'd0);

        // 3C x A5: tile operands per step, then the product
        in_a = 8'h3C; in_b = 8'hA5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a = 8'h00; in_b = 8'h00;  // changes after capture must not matter
        for (int s = 0; s < 4; s++) begin
            check($sformatf("t2 mul_a s%0d", s), 32'(mul_a), 32'(exp_a[s]));
            check($sformatf("t2 mul_b s%0d", s), 32'(mul_b), 32'(exp_b[s]));
            check($sformatf("t2 ov s%0d", s), 32'(out_valid), 32'd0);
            check($sformatf("t2 rdy s%0d", s), 32'(in_ready), 32'd0);
            tick();
        end
        check("t2 out_valid", 32'(out_valid), 32'd1);
        check("t2 product",   32'(product),   32'h26AC);
        check("t2 mul_a idle", 32'(mul_a),    32'd0);
        check("t2 busy",      32'(busy),      32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2 op_count", 32'(op_count), 32'd1);

        // FF x FF with out_ready already high
        in_a = 8'hFF; in_b = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("t3 out_valid", 32'(out_valid), 32'd1);
        check("t3 product",   32'(product),   32'hFE01);
        check("t3 cnt before", 32'(op_count), 32'd1);
        tick();
        out_ready = 1'b0;
        check("t3 cnt after", 32'(op_count),  32'd2);
        check("t3 in_ready",  32'(in_ready),  32'd1);
        check("t3 out_valid0", 32'(out_valid), 32'd0);

        // Stall in DONE for 10 cycles while a second request is offered
        in_a = 8'hFF; in_b = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        in_a = 8'h01; in_b = 8'h01; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("t4 product c%0d", c), 32'(product), 32'hFE01);
            check($sformatf("t4 in_ready c%0d", c), 32'(in_ready), 32'd0);
            check($sformatf("t4 out_valid c%0d", c), 32'(out_valid), 32'd1);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t4 op_count", 32'(op_count), 32'd3);
        check("t4 in_ready", 32'(in_ready), 32'd1);
        check("t4 not captured", 32'(product), 32'hFE01);
        tick();
        check("t4 still idle", 32'(busy), 32'd0);

        // Back-to-back with in_valid and out_ready both held high
        j = 0; k = 0; last = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 60 && k < 3; t++) begin
            if (out_valid) begin
                check($sformatf("t6 product %0d", k), 32'(product), 32'(bb_p[k]));
                if (k > 0) check($sformatf("t6 spacing %0d", k), 32'(cyc - last), 32'd6);
                last = cyc;
                k++;
            end
            if (in_ready && j < 3) begin
                in_a = bb_a[j]; in_b = bb_b[j]; in_valid = 1'b1;
                j++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("t6 ops seen", 32'(k), 32'd3);
        tick();
        out_ready = 1'b0;
        check("t6 op_count", 32'(op_count), 32'd6);

        // Counter wrap
        for (int i = 0; i < 9; i++) do_op(8'(i * 17 + 5), 8'h03, "wrap");
        check("wrap max", 32'(op_count), 32'hF);
        do_op(8'hAB, 8'hCD, "wrap last");
        check("wrap zero", 32'(op_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
